// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory loader and its memory.
package mips_pkg;

   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned IMEM_ADDR_W    = 10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACCEPT,
      ST_WRITE,
      ST_DONE,
      ST_ERROR
   } loader_state_t;

   // Little-endian byte lane select: idx 0 is bits [7:0].
   function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
      return word[8*idx +: 8];
   endfunction

endpackage

// File: rtl/imem_loader.sv
// Writer side of the byte-wide instruction memory: takes 32-bit words from a
// valid/ready stream and stores each as four bytes, LSB first, from BASE_ADDR up.
module imem_loader
   import mips_pkg::*;
#(
   parameter int unsigned ADDR_W    = IMEM_ADDR_W,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              word_valid,
   input  logic [31:0]       word_data,
   input  logic              word_last,
   output logic              word_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              overflow_err,
   output logic [ADDR_W-2:0] words_loaded
);

   // Word alignment keeps every word clear of the wrap point.
   if ((BASE_ADDR % BYTES_PER_WORD) != 0) begin : g_bad_base_align
      $error("imem_loader: BASE_ADDR must be a multiple of BYTES_PER_WORD");
   end
   if (BASE_ADDR >= (32'd1 << ADDR_W)) begin : g_bad_base_range
      $error("imem_loader: BASE_ADDR lies outside the memory");
   end

   localparam logic [ADDR_W-1:0] BASE_PTR  = ADDR_W'(BASE_ADDR);
   localparam logic [1:0]        LAST_BYTE = 2'(BYTES_PER_WORD - 1);

   loader_state_t     state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [1:0]        idx_q, idx_d;
   logic [31:0]       word_q, word_d;
   logic              last_q, last_d;
   logic [ADDR_W-2:0] words_d;
   logic              done_d, ovf_d;
   logic              ready_d, busy_d, we_d;
   logic [ADDR_W-1:0] addr_d;
   logic [7:0]        wdata_d;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic; outputs are derived from the next state so they are
   // registered yet line up with the state they describe.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      word_d  = word_q;
      last_d  = last_q;
      words_d = words_loaded;
      done_d  = done;
      ovf_d   = overflow_err;

      case (state_q)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start) begin
               state_d = ST_ACCEPT;
               ptr_d   = BASE_PTR;
               words_d = '0;
               done_d  = 1'b0;
               ovf_d   = 1'b0;
            end
         end
         ST_ACCEPT: begin
            if (word_valid && word_ready) begin
               state_d = ST_WRITE;
               word_d  = word_data;
               last_d  = word_last;
               idx_d   = '0;
            end
         end
         ST_WRITE: begin
            ptr_d = ptr_q + 1'b1;
            idx_d = idx_q + 1'b1;
            if (idx_q == LAST_BYTE) begin
               words_d = words_loaded + 1'b1;
               if (last_q) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else if (ptr_d == '0) begin
                  state_d = ST_ERROR;
                  ovf_d   = 1'b1;
               end else begin
                  state_d = ST_ACCEPT;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      ready_d = (state_d == ST_ACCEPT);
      busy_d  = (state_d == ST_ACCEPT) || (state_d == ST_WRITE);
      we_d    = (state_d == ST_WRITE);
      addr_d  = mem_addr;
      wdata_d = mem_wdata;
      if (we_d) begin
         addr_d  = ptr_d;
         wdata_d = word_byte(word_d, idx_d);
      end
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q        <= BASE_PTR;
         idx_q        <= '0;
         word_q       <= '0;
         last_q       <= 1'b0;
         words_loaded <= '0;
         done         <= 1'b0;
         overflow_err <= 1'b0;
         word_ready   <= 1'b0;
         busy         <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
      end else begin
         ptr_q        <= ptr_d;
         idx_q        <= idx_d;
         word_q       <= word_d;
         last_q       <= last_d;
         words_loaded <= words_d;
         done         <= done_d;
         overflow_err <= ovf_d;
         word_ready   <= ready_d;
         busy         <= busy_d;
         mem_we       <= we_d;
         mem_addr     <= addr_d;
         mem_wdata    <= wdata_d;
      end
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the byte-addressable, little-endian instruction memory. The memory is 1024 bytes, and each instruction word is {mem[PC+3], mem[PC+2], mem[PC+1], mem[PC]}.
- The block accepts 32-bit instruction words over a valid/ready stream and writes each word into the byte-wide memory write port. It writes four consecutive bytes per word, LSB first, at increasing addresses.
- It sits between the boot/test program source and the instruction memory. The processor is held off, via `busy`, until the load completes.

Parameters:
- ADDR_W, 10, byte address width (memory depth = 2**ADDR_W bytes).
- BASE_ADDR, 0, first byte address written. Must be a multiple of 4; elaboration fails otherwise.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a load at BASE_ADDR. Sampled only in IDLE, DONE or ERROR.
- word_valid  in  1  source presents a word.
- word_data  in  32  instruction word.
- word_last  in  1  qualifies word_data; marks the final word of the program.
- word_ready  out  1  loader accepts a word this cycle.
- mem_we  out  1  byte write strobe to the instruction memory.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  8  byte to write.
- busy  out  1  load in progress (ACCEPT or WRITE state).
- done  out  1  level: load finished cleanly; held until the next start.
- overflow_err  out  1  level: memory end reached before word_last; held until the next start.
- words_loaded  out  ADDR_W-1  count of words fully written in the current load.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE.
  - All outputs 0: word_ready, mem_we, mem_addr, mem_wdata, busy, done, overflow_err, words_loaded.
  - Internal pointer is set to BASE_ADDR and byte_idx to 0.
  - Bytes already written stay in memory; the loader never clears memory.
- States: IDLE, ACCEPT, WRITE, DONE, ERROR.
- IDLE/DONE/ERROR, start=1:
  - Clear done, overflow_err and words_loaded.
  - Set pointer to BASE_ADDR.
  - Go to ACCEPT.
- start in ACCEPT or WRITE is ignored.
- ACCEPT:
  - word_ready=1 (registered; asserted every ACCEPT cycle) and busy=1.
  - On word_valid & word_ready: latch word_data and word_last, set byte_idx=0, go to WRITE.
  - word_valid=0: stay in ACCEPT; the source may idle indefinitely.
- WRITE (4 cycles):
  - Outputs: mem_we=1, mem_addr=pointer, mem_wdata=word[8*byte_idx+7 : 8*byte_idx], word_ready=0.
  - Each cycle: pointer+=1 (mod 2**ADDR_W) and byte_idx+=1.
  - After byte_idx=3, words_loaded+=1, then:
    - latched last=1 -> DONE (done=1).
    - else pointer wrapped to 0 -> ERROR (overflow_err=1).
    - else -> ACCEPT.
- Handshake timing: the cycle after the handshake carries byte 0. Throughput is one word per 5 cycles minimum.
- The source must hold word_data and word_last stable while word_valid=1 and word_ready=0.
- mem_we, mem_addr and mem_wdata are registered. mem_we=0 in every state except WRITE; mem_addr and mem_wdata are don't-care when mem_we=0.
- Boundary conditions:
  - word_last on the word ending at byte 2**ADDR_W-1 -> DONE, not ERROR.
  - A word is never split across the wrap point because BASE_ADDR is aligned.
  - ERROR is terminal until start or reset; word_ready stays 0.
  - Reset during WRITE aborts the word and drops mem_we immediately; partial bytes remain in memory.

Decomposition:
- Shared package (mips_pkg):
  - loader state enum.
  - BYTES_PER_WORD=4.
  - IMEM_ADDR_W=10 (shared with the instruction memory, so the reader and writer agree on depth).
- No sub-module: a single FSM with pointer and byte counter.
- The testbench pairs the loader with a writable byte RAM and reads back through the same little-endian word assembly used by the instruction memory.

Test Plan:
1. Reset asserted mid-run -> all outputs 0 the same cycle; after release, state IDLE and word_ready=0.
2. start; one word 0x00011020 with last=1 -> handshake cycle N; mem_we=1 cycles N+1..N+4; writes addr 0..3 = 0x20, 0x10, 0x01, 0x00; then done=1, words_loaded=1, busy=0; read-back at PC=0 gives 0x00011020.
3. Words 0x00421022, 0x20420010, 0x8CA40004 with valid gaps of 0, 3 and 7 cycles, last on the third -> bytes land at 0..11 in order; words_loaded=3; word_ready is never high during WRITE.
4. BASE_ADDR=1016, three words, none last -> first two written at 1016..1023; then overflow_err=1, done=0, words_loaded=2, word_ready stays 0, and the third word is never accepted. Repeat with last on the second word -> done=1, overflow_err=0.
5. Reset asserted during the WRITE of byte 2 -> mem_we falls immediately; bytes 0–1 remain in RAM and byte 2 is not written; a new start reloads from BASE_ADDR.
6. start pulsed during ACCEPT and WRITE -> ignored: pointer, words_loaded and state are unchanged.
